// File: rtl/frame_border_pad.sv
// rtl/frame_border_pad.sv - raster generator centring a FWFT-fed image inside a constant border.
// Optional macro FRAME_PAD_TEST_PATTERN_EN adds pattern_en_i and eight vertical colour bars.
module frame_border_pad #(
    parameter int                    DATA_WIDTH   = 24,
    parameter int                    CNT_BITS     = 12,
    parameter int                    H_ACTIVE     = 1920,
    parameter int                    H_FP         = 88,
    parameter int                    H_SYNC       = 44,
    parameter int                    H_BP         = 148,
    parameter int                    V_ACTIVE     = 1080,
    parameter int                    V_FP         = 4,
    parameter int                    V_SYNC       = 5,
    parameter int                    V_BP         = 36,
    parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = 24'h000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [10:0]           img_width_i,
    input  logic [10:0]           img_height_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    input  logic                  pix_valid_i,
`ifdef FRAME_PAD_TEST_PATTERN_EN
    input  logic                  pattern_en_i,
`endif
    output logic                  pix_rd_o,
    output logic                  vs_o,
    output logic                  hs_o,
    output logic                  de_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  frame_start_o,
    output logic                  underflow_o
);

    localparam int CW = CNT_BITS + 1;

    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_BITS-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0]         w_q, w_d, h_q, h_d;
    logic [CW-1:0]         off_x_q, off_x_d, off_y_q, off_y_d;
    logic                  vs_q, vs_d, hs_q, hs_d, de_q, de_d;
    logic                  frame_start_q, frame_start_d, underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [CW-1:0] hx, vy, img_w, img_h;
    logic          origin, act, win, pat_on, pix_rd;

`ifdef FRAME_PAD_TEST_PATTERN_EN
    localparam int BW = CW + 3;
    logic [CW-1:0]         rel_x;
    logic [2:0]            bar_idx;
    logic [DATA_WIDTH-1:0] bar_color;

    // floor(rel_x*8/w) found by counting thresholds, avoiding a divider
    always_comb begin
        rel_x   = hx - off_x_d;
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({rel_x, 3'b000} >= ({3'b000, w_d} * BW'(k)))
                bar_idx = bar_idx + 3'd1;
        end
        case (bar_idx)
            3'd0:    bar_color = DATA_WIDTH'(24'hFFFFFF);
            3'd1:    bar_color = DATA_WIDTH'(24'hFFFF00);
            3'd2:    bar_color = DATA_WIDTH'(24'h00FFFF);
            3'd3:    bar_color = DATA_WIDTH'(24'h00FF00);
            3'd4:    bar_color = DATA_WIDTH'(24'hFF00FF);
            3'd5:    bar_color = DATA_WIDTH'(24'hFF0000);
            3'd6:    bar_color = DATA_WIDTH'(24'h0000FF);
            default: bar_color = DATA_WIDTH'(24'h000000);
        endcase
    end

    assign pat_on = pattern_en_i;
`else
    assign pat_on = 1'b0;
`endif

    always_comb begin
        hx     = {1'b0, hcnt_q};
        vy     = {1'b0, vcnt_q};
        origin = (hcnt_q == '0) && (vcnt_q == '0);

        img_w = CW'(img_width_i);
        img_h = CW'(img_height_i);
        if (img_w > H_ACT) img_w = H_ACT;
        if (img_h > V_ACT) img_h = V_ACT;

        // The origin pixel already belongs to the new frame, so it sees the freshly latched size.
        w_d     = origin ? img_w : w_q;
        h_d     = origin ? img_h : h_q;
        off_x_d = origin ? ((H_ACT - img_w) >> 1) : off_x_q;
        off_y_d = origin ? ((V_ACT - img_h) >> 1) : off_y_q;

        act = (hx < H_ACT) && (vy < V_ACT);
        win = act && (hx >= off_x_d) && (hx < off_x_d + w_d)
                  && (vy >= off_y_d) && (vy < off_y_d + h_d);

        pix_rd = win && pix_valid_i && !pat_on && !rst_i;

        hcnt_d = (hx == H_LAST) ? '0 : hcnt_q + 1'b1;
        if (hx == H_LAST)
            vcnt_d = (vy == V_LAST) ? '0 : vcnt_q + 1'b1;
        else
            vcnt_d = vcnt_q;

        vs_d          = (vy >= V_SYNC_S) && (vy < V_SYNC_E);
        hs_d          = (hx >= H_SYNC_S) && (hx < H_SYNC_E);
        de_d          = act;
        frame_start_d = origin;
        underflow_d   = underflow_q || (win && !pix_valid_i && !pat_on);

        data_d = BORDER_COLOR;
        if (pix_rd)
            data_d = pix_data_i;
`ifdef FRAME_PAD_TEST_PATTERN_EN
        if (pat_on && win)
            data_d = bar_color;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            w_q           <= '0;
            h_q           <= '0;
            off_x_q       <= '0;
            off_y_q       <= '0;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            data_q        <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            w_q           <= w_d;
            h_q           <= h_d;
            off_x_q       <= off_x_d;
            off_y_q       <= off_y_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            data_q        <= data_d;
        end
    end

    assign pix_rd_o      = pix_rd;
    assign vs_o          = vs_q;
    assign hs_o          = hs_q;
    assign de_o          = de_q;
    assign data_o        = data_q;
    assign frame_start_o = frame_start_q;
    assign underflow_o   = underflow_q;

endmodule

// File: doc/frame_border_pad.md
Name: frame_border_pad

Overview:
- Video timing transmitter. Generates a full raster (vs/hs/de) and places a smaller source image, read from a first-word-fall-through pixel FIFO, centred in the active area.
- Fills everything outside the image window with a constant border colour.
- Sits at the output side of the scaler/frame-buffer path, feeding the HDMI TX / display encoder.
- Produces the stream format the crop stage consumes: positive vs/hs, de stable across a line.

Parameters:
- DATA_WIDTH, 24, pixel width.
- CNT_BITS, 12, h/v counter width.
- H_ACTIVE, 1920, active pixels per line.
- H_FP, 88, h front porch (clocks).
- H_SYNC, 44, hs width (clocks).
- H_BP, 148, h back porch (clocks).
- V_ACTIVE, 1080, active lines.
- V_FP, 4, v front porch (lines).
- V_SYNC, 5, vs width (lines).
- V_BP, 36, v back porch (lines).
- BORDER_COLOR, 24'h000000, fill value outside the window and on underflow.

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  synchronous, active-high reset.
- img_width_i  in  11  source image width.
- img_height_i  in  11  source image height.
- pix_data_i  in  DATA_WIDTH  FIFO head word (FWFT).
- pix_valid_i  in  1  FIFO not empty.
- pix_rd_o  out  1  FIFO pop; combinational.
- vs_o  out  1  vertical sync, active high.
- hs_o  out  1  horizontal sync, active high.
- de_o  out  1  data enable.
- data_o  out  DATA_WIDTH  pixel out.
- frame_start_o  out  1  one-cycle pulse aligned with the first active pixel of a frame.
- underflow_o  out  1  sticky underflow flag; cleared only by rst_i.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - hcnt = 0, vcnt = 0.
  - All outputs 0: vs_o, hs_o, de_o, data_o, frame_start_o, underflow_o.
  - Latched offsets and sizes = 0.
- Raster counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL likewise.
  - hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments on each hcnt wrap, 0..V_TOTAL-1, then wraps.
  - Counting starts at hcnt = vcnt = 0 on the first cycle after reset is released.
- Stage-0 decodes (from counters):
  - act = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, held for whole lines.
- Size latch:
  - When hcnt = 0 and vcnt = 0, latch w = min(img_width_i, H_ACTIVE) and h = min(img_height_i, V_ACTIVE).
  - Compute off_x = (H_ACTIVE-w)>>1 and off_y = (V_ACTIVE-h)>>1 (floor).
  - Input changes mid-frame take effect at the next frame.
  - w = 0 or h = 0 gives an empty window: all border, no reads.
- Window:
  - win = act && off_x <= hcnt < off_x+w && off_y <= vcnt < off_y+h.
  - Compare at CNT_BITS+1 width so there is no overflow.
- Read handshake:
  - pix_rd_o = win && pix_valid_i, combinational, same cycle as the stage-0 counter value.
  - Exactly one pop per window pixel that has data.
- Output register, 1-cycle latency from counters:
  - vs_o <= vs, hs_o <= hs, de_o <= act.
  - data_o <= pix_data_i when pix_rd_o is high; otherwise BORDER_COLOR.
  - Outside de, data_o = BORDER_COLOR.
- Underflow:
  - Condition: win && !pix_valid_i.
  - Output that pixel as BORDER_COLOR; do not pop; set underflow_o (sticky).
  - Raster timing never stalls. A short line is not re-aligned; later pixels shift.
- frame_start_o <= (hcnt = 0 && vcnt = 0), registered, so it is coincident with the first de_o of the frame.
- rst_i asserted mid-frame: on the next edge, outputs go to 0 and counters to 0. No pops while rst_i is high (pix_rd_o forced 0).

Optional Feature:
- Macro: FRAME_PAD_TEST_PATTERN_EN.
- Defined:
  - Adds input port pattern_en_i (1 bit).
  - While pattern_en_i = 1: pix_rd_o is held 0 and underflow is not flagged.
  - Window pixels become 8 vertical colour bars, bar index = ((hcnt-off_x)*8)/w.
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black (8-bit saturated per channel, packed R[23:16] G[15:8] B[7:0]).
  - Border is unchanged.
- Undefined: no port, no pattern logic; behaviour exactly as above.

Test Plan:
- Small raster: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=8, V_FP=V_SYNC=V_BP=1.
  - Stimulus: reset release, FIFO never empty, img 8x4.
  - Required: hs_o high at clocks 19-20 of each 22-clock line; vs_o high for line 9 only.
  - Required: de_o 16 clocks per line on lines 0-7.
  - Required: pops at x 4..11, y 2..5; 32 pops per frame; border pixels = BORDER_COLOR.
- Latency: first pop on line 2, hcnt 4 -> data_o equals that word on the next edge with de_o = 1. frame_start_o pulses exactly once per 242 clocks.
- Underflow: pix_valid_i dropped for 3 window cycles -> 3 BORDER_COLOR pixels, no pops, underflow_o = 1 and held until rst_i; raster period unchanged.
- Size change: img changed from 8x4 to 16x8 mid-frame -> current frame keeps 32 pops; next frame does 128 pops with off = 0.
- Clamp and odd sizes:
  - img 40x3 -> w = 16, off_x = 0, off_y = 2 (floor of 5/2).
  - img 0x0 -> zero pops, all border.
- Mid-frame reset: rst_i high for 1 cycle at vcnt = 4 -> all outputs 0 next cycle, pix_rd_o = 0 during reset, raster restarts at 0,0.
